// File: rtl/path_dumper_pkg.sv
// Shared definitions for the path replay logic: FSM state encoding and the
// move direction codes used by the solver, the stack and this dumper.
package path_dumper_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_POP  = 3'd1;
    localparam logic [2:0] ST_CAPT = 3'd2;
    localparam logic [2:0] ST_EMIT = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    // Direction codes travel through this block untouched; it never decodes them.
    localparam logic [1:0] MOVE_UP    = 2'd0;
    localparam logic [1:0] MOVE_RIGHT = 2'd1;
    localparam logic [1:0] MOVE_DOWN  = 2'd2;
    localparam logic [1:0] MOVE_LEFT  = 2'd3;

endpackage

// File: rtl/path_buf.sv
// Local move buffer: WIDTH x 2**LENGTH register array, synchronous write,
// combinational read. Contents are never reset.
module path_buf
    import path_dumper_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [LENGTH-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [LENGTH-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem_q [2**LENGTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/path_dumper.sv
// Drains the move stack into a local buffer, then replays the moves in push
// order over a valid/ready stream.
module path_dumper
    import path_dumper_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int LENGTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stk_empty,
    input  logic [WIDTH-1:0]  stk_data,
    output logic              stk_pop,
    output logic [WIDTH-1:0]  move_data,
    output logic              move_valid,
    input  logic              move_ready,
    output logic              busy,
    output logic              done,
    output logic [LENGTH-1:0] path_len
);

    logic [2:0]        state_q, state_d;
    logic [LENGTH-1:0] idx_q, idx_d;
    logic [LENGTH-1:0] ptr_q, ptr_d;
    logic [LENGTH-1:0] path_len_q, path_len_d;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        path_len_d = path_len_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    path_len_d = '0;
                    if (stk_empty) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_POP;
                        idx_d   = '0;
                    end
                end
            end
            ST_POP: begin
                state_d = ST_CAPT;
            end
            // stk_empty here already reflects the pop just taken, so this entry is the last one.
            ST_CAPT: begin
                idx_d      = idx_q + LENGTH'(1);
                path_len_d = idx_q + LENGTH'(1);
                if (stk_empty) begin
                    state_d = ST_EMIT;
                    ptr_d   = idx_q;
                end else begin
                    state_d = ST_POP;
                end
            end
            ST_EMIT: begin
                if (move_ready) begin
                    if (ptr_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        ptr_d = ptr_q - LENGTH'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ptr_q      <= '0;
            path_len_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            path_len_q <= path_len_d;
        end
    end

    // Buffer slot 0 holds the top of the stack, i.e. the most recently pushed move.
    path_buf #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) u_buf (
        .clk   (clk),
        .we    (state_q == ST_CAPT),
        .waddr (idx_q),
        .wdata (stk_data),
        .raddr (ptr_q),
        .rdata (move_data)
    );

    assign stk_pop    = (state_q == ST_POP);
    assign move_valid = (state_q == ST_EMIT);
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign path_len   = path_len_q;

endmodule
